// File: rtl/cpu_sequencer_pkg.sv
// cpu_defs: shared definitions for the multi-cycle CPU sequencer.
// Holds the opcode map, ALU operation codes, PC source codes, the FSM
// state encoding and the field widths used by the sequencer and its
// decoder.
package cpu_defs;

    localparam int OPCODE_W = 8;
    localparam int ALU_OP_W = 3;

    localparam logic [OPCODE_W-1:0] OP_LOADI = 8'h00;
    localparam logic [OPCODE_W-1:0] OP_MOV   = 8'h01;
    localparam logic [OPCODE_W-1:0] OP_ADD   = 8'h02;
    localparam logic [OPCODE_W-1:0] OP_SUB   = 8'h03;
    localparam logic [OPCODE_W-1:0] OP_AND   = 8'h04;
    localparam logic [OPCODE_W-1:0] OP_OR    = 8'h05;
    localparam logic [OPCODE_W-1:0] OP_J     = 8'h06;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 8'h07;
    localparam logic [OPCODE_W-1:0] OP_LWD   = 8'h08;
    localparam logic [OPCODE_W-1:0] OP_LWI   = 8'h09;
    localparam logic [OPCODE_W-1:0] OP_SWD   = 8'h0A;
    localparam logic [OPCODE_W-1:0] OP_SWI   = 8'h0B;

    localparam logic [ALU_OP_W-1:0] ALU_FWD = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;

    localparam logic [1:0] PCS_NEXT   = 2'b00;
    localparam logic [1:0] PCS_JUMP   = 2'b01;
    localparam logic [1:0] PCS_BRANCH = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: bundle between the sequencer and the CPU datapath.
//   Datapath -> sequencer : INSTR_VALID, OPCODE, ZERO, BUSYWAIT
//   Sequencer -> datapath : INSTR_LATCH, ALU_OP, ALU_SRC, TWOS_COMP,
//                           REG_WRITE, MEM_READ, MEM_WRITE, MEM_TO_REG,
//                           PC_WRITE, PC_SRC, ILLEGAL, MEM_ERR, STATE
// The datapath side is the master, the sequencer is the slave.
interface cpu_sequencer_if;

    logic                          INSTR_VALID;
    logic [cpu_defs::OPCODE_W-1:0] OPCODE;
    logic                          ZERO;
    logic                          BUSYWAIT;

    logic                          INSTR_LATCH;
    logic [cpu_defs::ALU_OP_W-1:0] ALU_OP;
    logic                          ALU_SRC;
    logic                          TWOS_COMP;
    logic                          REG_WRITE;
    logic                          MEM_READ;
    logic                          MEM_WRITE;
    logic                          MEM_TO_REG;
    logic                          PC_WRITE;
    logic [1:0]                    PC_SRC;
    logic                          ILLEGAL;
    logic                          MEM_ERR;
    logic [2:0]                    STATE;

    modport master (
        output INSTR_VALID, OPCODE, ZERO, BUSYWAIT,
        input  INSTR_LATCH, ALU_OP, ALU_SRC, TWOS_COMP, REG_WRITE,
               MEM_READ, MEM_WRITE, MEM_TO_REG, PC_WRITE, PC_SRC,
               ILLEGAL, MEM_ERR, STATE
    );

    modport slave (
        input  INSTR_VALID, OPCODE, ZERO, BUSYWAIT,
        output INSTR_LATCH, ALU_OP, ALU_SRC, TWOS_COMP, REG_WRITE,
               MEM_READ, MEM_WRITE, MEM_TO_REG, PC_WRITE, PC_SRC,
               ILLEGAL, MEM_ERR, STATE
    );

endinterface

// File: rtl/cpu_sequencer_decode.sv
// sequencer_decode: combinational map from the latched opcode to ALU
// controls, instruction class bits and write-back enables.
//   i_opcode       latched opcode
//   o_alu_op       ALU operation code
//   o_alu_src      1 = immediate operand
//   o_twos_comp    1 = negate operand 2
//   o_is_alu       register/ALU instruction, retires via WB
//   o_is_load      lwd/lwi
//   o_is_store     swd/swi
//   o_is_jump      j
//   o_is_branch    beq
//   o_is_illegal   opcode outside the defined set
//   o_reg_wen      instruction writes the register file
//   o_mem_to_reg   write-back data comes from memory
module sequencer_decode
    import cpu_defs::*;
(
    input  logic [OPCODE_W-1:0] i_opcode,
    output logic [ALU_OP_W-1:0] o_alu_op,
    output logic                o_alu_src,
    output logic                o_twos_comp,
    output logic                o_is_alu,
    output logic                o_is_load,
    output logic                o_is_store,
    output logic                o_is_jump,
    output logic                o_is_branch,
    output logic                o_is_illegal,
    output logic                o_reg_wen,
    output logic                o_mem_to_reg
);

    always_comb begin
        o_alu_op     = ALU_FWD;
        o_alu_src    = 1'b0;
        o_twos_comp  = 1'b0;
        o_is_alu     = 1'b0;
        o_is_load    = 1'b0;
        o_is_store   = 1'b0;
        o_is_jump    = 1'b0;
        o_is_branch  = 1'b0;
        o_is_illegal = 1'b0;
        case (i_opcode)
            OP_LOADI: begin o_alu_src = 1'b1; o_is_alu = 1'b1; end
            OP_MOV:   o_is_alu = 1'b1;
            OP_ADD:   begin o_alu_op = ALU_ADD; o_is_alu = 1'b1; end
            OP_SUB:   begin o_alu_op = ALU_ADD; o_twos_comp = 1'b1; o_is_alu = 1'b1; end
            OP_AND:   begin o_alu_op = ALU_AND; o_is_alu = 1'b1; end
            OP_OR:    begin o_alu_op = ALU_OR;  o_is_alu = 1'b1; end
            OP_J:     o_is_jump = 1'b1;
            OP_BEQ:   begin o_alu_op = ALU_ADD; o_twos_comp = 1'b1; o_is_branch = 1'b1; end
            OP_LWD:   o_is_load = 1'b1;
            OP_LWI:   begin o_alu_src = 1'b1; o_is_load = 1'b1; end
            OP_SWD:   o_is_store = 1'b1;
            OP_SWI:   begin o_alu_src = 1'b1; o_is_store = 1'b1; end
            default:  o_is_illegal = 1'b1;
        endcase
        o_reg_wen    = o_is_alu | o_is_load;
        o_mem_to_reg = o_is_load;
    end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control FSM for the 8-bit CPU datapath
// (FETCH -> DECODE -> EXEC -> MEM -> WB), stalling on instruction and
// data memory, with a bounded wait in MEM.
//   CLK, RESET   rising-edge clock, synchronous active-high reset
//   bus          cpu_sequencer_if slave: OPCODE/INSTR_VALID/ZERO/BUSYWAIT
//                in, datapath control strobes, error pulses and STATE out
// Parameters: MEM_TIMEOUT (1..255) cycles of BUSYWAIT before abort,
//             CNT_W wait-counter width (2^CNT_W > MEM_TIMEOUT).
module cpu_sequencer
    import cpu_defs::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
)(
    input  logic           CLK,
    input  logic           RESET,
    cpu_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t              r_state;
    logic [OPCODE_W-1:0] r_opcode;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_timeout;

    logic [ALU_OP_W-1:0] w_alu_op;
    logic                w_alu_src, w_twos_comp;
    logic                w_is_alu, w_is_load, w_is_store;
    logic                w_is_jump, w_is_branch, w_is_illegal;
    logic                w_reg_wen, w_mem_to_reg;

    sequencer_decode u_decode (
        .i_opcode     (r_opcode),
        .o_alu_op     (w_alu_op),
        .o_alu_src    (w_alu_src),
        .o_twos_comp  (w_twos_comp),
        .o_is_alu     (w_is_alu),
        .o_is_load    (w_is_load),
        .o_is_store   (w_is_store),
        .o_is_jump    (w_is_jump),
        .o_is_branch  (w_is_branch),
        .o_is_illegal (w_is_illegal),
        .o_reg_wen    (w_reg_wen),
        .o_mem_to_reg (w_mem_to_reg)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= ST_FETCH;
            r_opcode  <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (bus.INSTR_VALID) begin
                        r_opcode <= bus.OPCODE;
                        r_state  <= ST_DECODE;
                    end
                end
                ST_DECODE: r_state <= w_is_illegal ? ST_WB : ST_EXEC;
                ST_EXEC: begin
                    if (w_is_alu) begin
                        r_state <= ST_WB;
                    end else if (w_is_load || w_is_store) begin
                        r_cnt   <= '0;
                        r_state <= ST_MEM;
                    end else begin
                        // j and beq redirect the PC here and retire directly.
                        r_state <= ST_FETCH;
                    end
                end
                ST_MEM: begin
                    // A free BUSYWAIT always wins, even on the last allowed cycle.
                    if (!bus.BUSYWAIT) begin
                        r_state <= ST_WB;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == TIMEOUT_LAST) begin
                            r_timeout <= 1'b1;
                            r_state   <= ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    r_timeout <= 1'b0;
                    r_state   <= ST_FETCH;
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    logic                w_latch, w_reg_write, w_mem_read, w_mem_write;
    logic                w_m2r_out, w_pc_write, w_illegal, w_mem_err;
    logic                w_alu_src_out, w_twos_out;
    logic [ALU_OP_W-1:0] w_alu_op_out;
    logic [1:0]          w_pc_src;
    logic [2:0]          w_state_out;

    // Outputs depend on state and latched opcode only (plus ZERO in EXEC);
    // RESET masks everything so the datapath sees an idle bus immediately.
    always_comb begin
        w_latch       = 1'b0;
        w_alu_op_out  = ALU_FWD;
        w_alu_src_out = 1'b0;
        w_twos_out    = 1'b0;
        w_reg_write   = 1'b0;
        w_mem_read    = 1'b0;
        w_mem_write   = 1'b0;
        w_m2r_out     = 1'b0;
        w_pc_write    = 1'b0;
        w_pc_src      = PCS_NEXT;
        w_illegal     = 1'b0;
        w_mem_err     = 1'b0;
        w_state_out   = 3'd0;
        if (!RESET) begin
            w_state_out = r_state;
            if (r_state != ST_FETCH) begin
                w_alu_op_out  = w_alu_op;
                w_alu_src_out = w_alu_src;
                w_twos_out    = w_twos_comp;
            end
            case (r_state)
                ST_FETCH: w_latch = 1'b1;
                ST_EXEC: begin
                    if (w_is_jump) begin
                        w_pc_write = 1'b1;
                        w_pc_src   = PCS_JUMP;
                    end else if (w_is_branch) begin
                        w_pc_write = 1'b1;
                        w_pc_src   = bus.ZERO ? PCS_BRANCH : PCS_NEXT;
                    end
                end
                ST_MEM: begin
                    w_mem_read  = w_is_load;
                    w_mem_write = w_is_store;
                end
                ST_WB: begin
                    w_pc_write  = 1'b1;
                    w_reg_write = w_reg_wen & ~w_is_illegal & ~r_timeout;
                    w_m2r_out   = w_mem_to_reg;
                    w_illegal   = w_is_illegal;
                    w_mem_err   = r_timeout;
                end
                default: ;
            endcase
        end
    end

    assign bus.INSTR_LATCH = w_latch;
    assign bus.ALU_OP      = w_alu_op_out;
    assign bus.ALU_SRC     = w_alu_src_out;
    assign bus.TWOS_COMP   = w_twos_out;
    assign bus.REG_WRITE   = w_reg_write;
    assign bus.MEM_READ    = w_mem_read;
    assign bus.MEM_WRITE   = w_mem_write;
    assign bus.MEM_TO_REG  = w_m2r_out;
    assign bus.PC_WRITE    = w_pc_write;
    assign bus.PC_SRC      = w_pc_src;
    assign bus.ILLEGAL     = w_illegal;
    assign bus.MEM_ERR     = w_mem_err;
    assign bus.STATE       = w_state_out;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed and randomized instruction sequences for
// cpu_sequencer, checked cycle by cycle against an instruction-level
// reference model of the expected control trace.
module tb_cpu_sequencer;

    localparam int TO = 4;

    logic CLK;
    logic RESET;
    int   n_assert = 0;
    int   n_fail   = 0;

    cpu_sequencer_if bus ();

    cpu_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(3)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // {ALU_OP, ALU_SRC, TWOS_COMP} per opcode, straight from the opcode table.
    function automatic logic [4:0] exp_alu(input logic [7:0] op);
        case (op)
            8'h00: return 5'b000_1_0;
            8'h01: return 5'b000_0_0;
            8'h02: return 5'b001_0_0;
            8'h03: return 5'b001_0_1;
            8'h04: return 5'b010_0_0;
            8'h05: return 5'b011_0_0;
            8'h06: return 5'b000_0_0;
            8'h07: return 5'b001_0_1;
            8'h08: return 5'b000_0_0;
            8'h09: return 5'b000_1_0;
            8'h0A: return 5'b000_0_0;
            8'h0B: return 5'b000_1_0;
            default: return 5'b000_0_0;
        endcase
    endfunction

    function automatic logic [17:0] mk(input logic lat, input logic [4:0] a,
                                       input logic rw, input logic mr, input logic mw,
                                       input logic m2r, input logic pcw, input logic [1:0] pcs,
                                       input logic ill, input logic merr, input logic [2:0] st);
        return {lat, a, rw, mr, mw, m2r, pcw, pcs, ill, merr, st};
    endfunction

    function automatic logic [17:0] obs();
        return {bus.INSTR_LATCH, bus.ALU_OP, bus.ALU_SRC, bus.TWOS_COMP, bus.REG_WRITE,
                bus.MEM_READ, bus.MEM_WRITE, bus.MEM_TO_REG, bus.PC_WRITE, bus.PC_SRC,
                bus.ILLEGAL, bus.MEM_ERR, bus.STATE};
    endfunction

    // Check one cycle at the falling edge, then advance past the next rising edge.
    task automatic step(input logic [17:0] exp, input string tag);
        logic [17:0] o;
        @(negedge CLK);
        o = obs();
        n_assert++;
        assert (o === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, exp);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic rnd_side();
        bus.ZERO        = 1'($urandom);
        bus.BUSYWAIT    = 1'($urandom);
        bus.INSTR_VALID = 1'($urandom);
        bus.OPCODE      = 8'($urandom);
    endtask

    // Drives one instruction from FETCH back to FETCH and checks every cycle.
    task automatic run_instr(input logic [7:0] op, input logic z, input int nbusy,
                             input int nwait, input string tag);
        logic [4:0] a;
        bit ill, ld, st, jmp, br, wbr, tmo;
        int m;
        a   = exp_alu(op);
        ill = (op > 8'h0B);
        ld  = (op == 8'h08) || (op == 8'h09);
        st  = (op == 8'h0A) || (op == 8'h0B);
        jmp = (op == 8'h06);
        br  = (op == 8'h07);
        wbr = (op <= 8'h05) || ld;
        tmo = 1'b0;
        for (int i = 0; i < nwait; i++) begin
            rnd_side();
            bus.INSTR_VALID = 1'b0;
            step(mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3'd0), {tag, ":fetch_wait"});
        end
        rnd_side();
        bus.INSTR_VALID = 1'b1;
        bus.OPCODE      = op;
        step(mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3'd0), {tag, ":fetch"});
        rnd_side();
        step(mk(0, a, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3'd1), {tag, ":decode"});
        if (!ill) begin
            rnd_side();
            bus.ZERO = z;
            step(mk(0, a, 0, 0, 0, 0, jmp || br,
                    jmp ? 2'b01 : ((br && z) ? 2'b10 : 2'b00), 0, 0, 3'd2), {tag, ":exec"});
            if (jmp || br) return;
            if (ld || st) begin
                tmo = (nbusy >= TO);
                m   = tmo ? TO : nbusy + 1;
                for (int i = 0; i < m; i++) begin
                    rnd_side();
                    bus.BUSYWAIT = (i < nbusy);
                    step(mk(0, a, 0, ld, st, 0, 0, 2'b00, 0, 0, 3'd3), {tag, ":mem"});
                end
            end
        end
        rnd_side();
        step(mk(0, a, wbr && !ill && !tmo, 0, 0, ld, 1, 2'b00, ill, tmo, 3'd4), {tag, ":wb"});
    endtask

    initial begin
        logic [7:0] op;
        logic [17:0] zero_v;
        logic [17:0] fetch_v;
        zero_v  = '0;
        fetch_v = mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3'd0);
        RESET           = 1'b1;
        bus.INSTR_VALID = 1'b0;
        bus.OPCODE      = 8'h00;
        bus.ZERO        = 1'b0;
        bus.BUSYWAIT    = 1'b0;
        @(posedge CLK);
        #1;
        step(zero_v, "reset0");
        bus.INSTR_VALID = 1'b1;
        step(zero_v, "reset1");
        RESET           = 1'b0;
        bus.INSTR_VALID = 1'b0;
        step(fetch_v, "post_reset_fetch");

        run_instr(8'h02, 1'b0, 0, 0, "add");
        run_instr(8'h07, 1'b1, 0, 0, "beq_taken");
        run_instr(8'h07, 1'b0, 0, 0, "beq_not_taken");
        run_instr(8'h06, 1'b0, 0, 0, "jump");
        run_instr(8'h09, 1'b0, 3, 0, "lwi_busy3");
        run_instr(8'h0A, 1'b0, 50, 0, "swd_timeout");
        run_instr(8'h3F, 1'b0, 0, 0, "illegal_3f");
        run_instr(8'h08, 1'b0, 0, 5, "lwd_fetch_stall");
        run_instr(8'h08, 1'b0, 4, 0, "lwd_timeout");

        // Reset asserted in the middle of a stalled swd access.
        bus.INSTR_VALID = 1'b1;
        bus.OPCODE      = 8'h0A;
        bus.BUSYWAIT    = 1'b0;
        step(fetch_v, "rst_mid:fetch");
        bus.INSTR_VALID = 1'b0;
        step(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3'd1), "rst_mid:decode");
        step(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3'd2), "rst_mid:exec");
        bus.BUSYWAIT = 1'b1;
        step(mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 3'd3), "rst_mid:mem");
        RESET = 1'b1;
        step(zero_v, "rst_mid:reset0");
        step(zero_v, "rst_mid:reset1");
        RESET = 1'b0;
        step(fetch_v, "rst_mid:release");

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 7) == 0) op = 8'($urandom_range(12, 255));
            else                          op = 8'($urandom_range(0, 11));
            run_instr(op, 1'($urandom), int'($urandom_range(0, 6)),
                      int'($urandom_range(0, 2)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
